// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter.
// State encoding, default widths and grant counter limits.
package dmem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_YIELD   = 3'd4
    } arb_state_e;

    localparam int WORD_SIZE_DEF = 16;
    localparam int GCNT_W        = 16;
    localparam int TMR_W         = 16;

    localparam logic [GCNT_W-1:0] GCNT_MAX = {GCNT_W{1'b1}};

endpackage

// File: rtl/dmem_bus_arbiter_steal_timer.sv
// Load/count/expire interval timer for cycle stealing.
// Present only when DMEM_CYCLE_STEAL_EN is defined.
`ifdef DMEM_CYCLE_STEAL_EN
module dmem_steal_timer
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Restart at zero on load, otherwise count one per cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == (limit - 1'b1));

endmodule
`endif

// File: rtl/dmem_bus_arbiter.sv
// Data-memory bus arbiter between cpu and DMA engine.
// Optional cycle stealing enabled by defining DMEM_CYCLE_STEAL_EN.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int STEAL_LEN = 4,
    parameter int CPU_SLOT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_readM,
    input  logic                 cpu_writeM,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic                 cpu_busy,
    input  logic                 BR,
    input  logic                 dma_writeM,
    input  logic [WORD_SIZE-1:0] dma_address,
    output logic                 BG,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    output logic                 cpu_stall,
    output logic [GCNT_W-1:0]    grant_cycles
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              bg_q;
    logic              bg_d;
    logic [GCNT_W-1:0] gcnt_q;
    logic [GCNT_W-1:0] gcnt_d;
    logic              cpu_req;
    logic              tmr_expire;

    assign cpu_req = cpu_readM | cpu_writeM;

`ifdef DMEM_CYCLE_STEAL_EN
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_limit;

    // Any state change restarts the interval being timed.
    assign tmr_load  = (state_d != state_q);
    assign tmr_limit = (state_q == ST_YIELD) ? TMR_W'(CPU_SLOT)
                                             : TMR_W'(STEAL_LEN);

    dmem_steal_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );
`else
    logic unused_cfg;

    assign tmr_expire = 1'b0;
    assign unused_cfg = (STEAL_LEN == CPU_SLOT);
`endif

    // Next-state logic for bus ownership.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (BR) begin
                    state_d = cpu_busy ? ST_DRAIN : ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if (!cpu_busy) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!BR) begin
                    state_d = ST_RELEASE;
                end else if (tmr_expire) begin
                    state_d = ST_YIELD;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            ST_YIELD: begin
                if (tmr_expire) begin
                    if (!BR) begin
                        state_d = ST_IDLE;
                    end else if (cpu_busy) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant flag and saturating grant-cycle counter.
    always_comb begin
        bg_d   = (state_d == ST_GRANT);
        gcnt_d = gcnt_q;
        if (bg_q && (gcnt_q != GCNT_MAX)) begin
            gcnt_d = gcnt_q + 1'b1;
        end
    end

    // State, grant and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bg_q    <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Bus owner mux and cpu stall.
    always_comb begin
        d_readM   = cpu_readM;
        d_writeM  = cpu_writeM;
        d_address = cpu_address;
        cpu_stall = 1'b0;
        unique case (state_q)
            ST_GRANT: begin
                d_readM   = 1'b0;
                d_writeM  = dma_writeM;
                d_address = dma_address;
                cpu_stall = cpu_req;
            end
            ST_RELEASE: begin
                d_readM   = 1'b0;
                d_writeM  = 1'b0;
                cpu_stall = cpu_req;
            end
            ST_DRAIN: begin
                cpu_stall = cpu_req & ~cpu_busy;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    assign BG           = bg_q;
    assign grant_cycles = gcnt_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Testbench for dmem_bus_arbiter.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_dmem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_readM;
    logic        cpu_writeM;
    logic [15:0] cpu_address;
    logic        cpu_busy;
    logic        BR;
    logic        dma_writeM;
    logic [15:0] dma_address;
    logic        BG;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    logic        cpu_stall;
    logic [15:0] grant_cycles;

    int n_vec;
    int n_err;

    dmem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_readM    (cpu_readM),
        .cpu_writeM   (cpu_writeM),
        .cpu_address  (cpu_address),
        .cpu_busy     (cpu_busy),
        .BR           (BR),
        .dma_writeM   (dma_writeM),
        .dma_address  (dma_address),
        .BG           (BG),
        .d_readM      (d_readM),
        .d_writeM     (d_writeM),
        .d_address    (d_address),
        .cpu_stall    (cpu_stall),
        .grant_cycles (grant_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        busy;
        logic        br;
        logic        dw;
        logic [15:0] ca;
        logic [15:0] da;
        logic [3:0]  exp_sig;
        logic [15:0] exp_addr;
        logic [15:0] exp_gc;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic busy,
        input logic br, input logic dw,
        input logic [15:0] ca, input logic [15:0] da,
        input logic [3:0] es, input logic [15:0] ea,
        input logic [15:0] eg
    );
        vec_t v;
        v.rd = rd;  v.wr = wr;  v.busy = busy;
        v.br = br;  v.dw = dw;
        v.ca = ca;  v.da = da;
        v.exp_sig  = es;
        v.exp_addr = ea;
        v.exp_gc   = eg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait for the next posedge, then move to the middle of the low phase.
    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic busy,
                         input logic br, input logic dw);
        cpu_readM  = rd;
        cpu_writeM = wr;
        cpu_busy   = busy;
        BR         = br;
        dma_writeM = dw;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cpu_address = 16'h1111;
        dma_address = 16'hD0D0;

        // {BG, d_readM, d_writeM, cpu_stall}
        tbl[0]  = mk(1,0,1,0,0, 16'h1111,16'hD0D0, 4'b0100, 16'h1111, 0);
        tbl[1]  = mk(0,1,1,1,0, 16'h1112,16'hD0D0, 4'b0010, 16'h1112, 0);
        tbl[2]  = mk(0,0,1,1,0, 16'h1113,16'hD0D0, 4'b0000, 16'h1113, 0);
        tbl[3]  = mk(1,0,0,1,0, 16'h1114,16'hD0D0, 4'b0101, 16'h1114, 0);
        tbl[4]  = mk(1,0,0,1,1, 16'h1115,16'hD0D1, 4'b1011, 16'hD0D1, 0);
        tbl[5]  = mk(0,0,0,1,0, 16'h1116,16'hD0D2, 4'b1000, 16'hD0D2, 1);
        tbl[6]  = mk(0,1,0,0,1, 16'h1117,16'hD0D3, 4'b1011, 16'hD0D3, 2);
        tbl[7]  = mk(1,0,0,1,0, 16'h1118,16'hD0D4, 4'b0001, 16'h1118, 3);
        tbl[8]  = mk(1,0,0,0,0, 16'h1119,16'hD0D5, 4'b0100, 16'h1119, 3);
        tbl[9]  = mk(0,0,0,1,0, 16'h111A,16'hD0D6, 4'b0000, 16'h111A, 3);
        tbl[10] = mk(0,0,0,1,1, 16'h111B,16'hD0D7, 4'b1010, 16'hD0D7, 3);
        tbl[11] = mk(0,0,0,0,0, 16'h111C,16'hD0D8, 4'b1000, 16'hD0D8, 4);
        tbl[12] = mk(1,1,0,0,0, 16'h111D,16'hD0D9, 4'b0001, 16'h111D, 5);

        @(negedge clk);
        edge_step();
        chk("reset_bg", {31'd0, BG}, 32'd0);
        chk("reset_gc", {16'd0, grant_cycles}, 32'd0);
        chk("reset_bus", {d_address, 15'd0, d_readM}, {16'h1111, 16'd0});
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].busy, tbl[i].br, tbl[i].dw);
            cpu_address = tbl[i].ca;
            dma_address = tbl[i].da;
            #1;
            chk($sformatf("vec%0d_sig", i),
                {28'd0, BG, d_readM, d_writeM, cpu_stall},
                {28'd0, tbl[i].exp_sig});
            chk($sformatf("vec%0d_addr", i), {16'd0, d_address},
                {16'd0, tbl[i].exp_addr});
            chk($sformatf("vec%0d_gc", i), {16'd0, grant_cycles},
                {16'd0, tbl[i].exp_gc});
            edge_step();
        end

        // Fast grant, then reset pulse mid-grant with BR still high.
        drive(0, 0, 0, 1, 0);
        cpu_address = 16'h2222;
        dma_address = 16'hABCD;
        #1;
        chk("fast_pre_bg", {31'd0, BG}, 32'd0);
        edge_step();
        chk("fast_bg", {31'd0, BG}, 32'd1);
        chk("fast_addr", {16'd0, d_address}, {16'd0, 16'hABCD});
        chk("fast_gc", {16'd0, grant_cycles}, 32'd5);
        edge_step();
        chk("fast_gc_inc", {16'd0, grant_cycles}, 32'd6);
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        #1;
        chk("rst_mid_bg", {31'd0, BG}, 32'd0);
        chk("rst_mid_gc", {16'd0, grant_cycles}, 32'd0);
        chk("rst_mid_addr", {16'd0, d_address}, {16'd0, 16'h2222});
        edge_step();
        chk("rst_regrant_bg", {31'd0, BG}, 32'd1);

        // Saturation of the grant-cycle counter.
        force dut.gcnt_q = 16'hFFFE;
        #1;
        release dut.gcnt_q;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            chk($sformatf("sat%0d", k), {16'd0, grant_cycles},
                {16'd0, 16'hFFFF});
        end

        // Drop BR and return to idle.
        drive(0, 0, 0, 0, 0);
        edge_step();
        edge_step();
        edge_step();
        chk("idle_back_bg", {31'd0, BG}, 32'd0);

`ifdef DMEM_CYCLE_STEAL_EN
        begin
            logic [11:0] exp_pat;
            logic [11:0] got_pat;
            exp_pat = 12'b1111_0_1111_0_11;
            got_pat = '0;
            drive(0, 0, 0, 1, 0);
            for (int c = 0; c < 12; c++) begin
                edge_step();
                got_pat[11-c] = BG;
            end
            chk("steal_pattern", {20'd0, got_pat}, {20'd0, exp_pat});
            drive(0, 0, 0, 0, 0);
            edge_step();
            edge_step();
            edge_step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
